// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetches sequentially from a combinational
// instruction memory into a circular buffer of {PC, Inst} pairs and hands
// the head entry to decode. A redirect flushes the queue and restarts fetch.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       En,
  output logic [31:0]                IF_ADDR,
  input  logic [31:0]                IF_Inst,
  input  logic                       Redirect,
  input  logic [31:0]                Redirect_PC,
  input  logic                       ID_Ready,
  output logic                       ID_Valid,
  output logic [31:0]                ID_Inst,
  output logic [31:0]                ID_PC,
  output logic [$clog2(DEPTH):0]     Count,
  output logic [15:0]                Redirect_Cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   r_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [15:0]   r_redir_cnt;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];

  logic          w_full;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;

  // Push/pop qualification; a full queue never pushes, even alongside a pop.
  always_comb begin
    w_full  = (r_count == FULL_CNT);
    w_valid = (r_count != {CW{1'b0}});
    w_push  = En & ~Redirect & ~w_full;
    w_pop   = En & ~Redirect & w_valid & ID_Ready;
  end

  // Fetch PC, pointers, occupancy and redirect counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_pc        <= RESET_PC;
      r_head      <= {AW{1'b0}};
      r_tail      <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_redir_cnt <= 16'h0000;
    end else if (En) begin
      if (Redirect) begin
        r_pc    <= {Redirect_PC[31:2], 2'b00};
        r_head  <= {AW{1'b0}};
        r_tail  <= {AW{1'b0}};
        r_count <= {CW{1'b0}};
        if (r_redir_cnt != 16'hFFFF) begin
          r_redir_cnt <= r_redir_cnt + 16'd1;
        end else begin
          r_redir_cnt <= r_redir_cnt;
        end
      end else begin
        if (w_push) begin
          r_pc   <= r_pc + 32'd4;      // wraps modulo 2^32 naturally
          r_tail <= r_tail + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          r_pc   <= r_pc;
          r_tail <= r_tail;
        end
        if (w_pop) begin
          r_head <= r_head + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          r_head <= r_head;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
          2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
          default: r_count <= r_count;
        endcase
      end
    end else begin
      r_pc        <= r_pc;
      r_head      <= r_head;
      r_tail      <= r_tail;
      r_count     <= r_count;
      r_redir_cnt <= r_redir_cnt;
    end
  end

  // Queue storage; written at the tail on every push, cleared by reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= 32'h0000_0000;
        r_mem_inst[i] <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_mem_pc[r_tail]   <= r_pc;
      r_mem_inst[r_tail] <= IF_Inst;
    end else begin
      r_mem_pc[r_tail]   <= r_mem_pc[r_tail];
      r_mem_inst[r_tail] <= r_mem_inst[r_tail];
    end
  end

  // Output drive: head entry gated to zero when the queue is empty.
  always_comb begin
    IF_ADDR      = r_pc;
    Count        = r_count;
    Redirect_Cnt = r_redir_cnt;
    ID_Valid     = w_valid;
    if (w_valid) begin
      ID_Inst = r_mem_inst[r_head];
      ID_PC   = r_mem_pc[r_head];
    end else begin
      ID_Inst = 32'h0000_0000;
      ID_PC   = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: fill, full, push/pop, enable hold,
// asynchronous reset, redirect and PC wrap-around.
module tb_if_prefetch_queue;

  logic        Clk = 1'b0;
  logic        Rst, En, Redirect, ID_Ready;
  logic [31:0] Redirect_PC;
  logic [31:0] IF_ADDR, IF_Inst, ID_Inst, ID_PC;
  logic        ID_Valid;
  logic [2:0]  Count;
  logic [15:0] Redirect_Cnt;

  logic        Rst2, En2, ID_Ready2;
  logic [31:0] IF_ADDR2, IF_Inst2, ID_Inst2, ID_PC2;
  logic        ID_Valid2;
  logic [2:0]  Count2;
  logic [15:0] Redirect_Cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  // ROM model: ROM[a] = a + 0x100
  assign IF_Inst  = IF_ADDR  + 32'h0000_0100;
  assign IF_Inst2 = IF_ADDR2 + 32'h0000_0100;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .IF_ADDR(IF_ADDR), .IF_Inst(IF_Inst),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC), .ID_Ready(ID_Ready),
    .ID_Valid(ID_Valid), .ID_Inst(ID_Inst), .ID_PC(ID_PC), .Count(Count),
    .Redirect_Cnt(Redirect_Cnt)
  );

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .Clk(Clk), .Rst(Rst2), .En(En2), .IF_ADDR(IF_ADDR2), .IF_Inst(IF_Inst2),
    .Redirect(1'b0), .Redirect_PC(32'h0000_0000), .ID_Ready(ID_Ready2),
    .ID_Valid(ID_Valid2), .ID_Inst(ID_Inst2), .ID_PC(ID_PC2), .Count(Count2),
    .Redirect_Cnt(Redirect_Cnt2)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (Count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
    checks++; if (ID_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ID_Valid); end
    checks++; if (IF_ADDR !== 32'h0) begin failures++; $display("FAIL reset_ifaddr got=%h exp=0", IF_ADDR); end
    checks++; if (ID_Inst !== 32'h0 || ID_PC !== 32'h0) begin failures++; $display("FAIL reset_id got=%h/%h exp=0/0", ID_Inst, ID_PC); end
    checks++; if (Redirect_Cnt !== 16'h0) begin failures++; $display("FAIL reset_rcnt got=%h exp=0", Redirect_Cnt); end
    tick();
    Rst = 1'b0;
    En  = 1'b1;
  endtask

  task automatic test_fill();
    tick();
    checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h0 || ID_Inst !== 32'h100) begin failures++; $display("FAIL fill_latency got=%b/%h/%h exp=1/0/100", ID_Valid, ID_PC, ID_Inst); end
    tick(); tick(); tick();
    checks++; if (Count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", Count); end
    checks++; if (IF_ADDR !== 32'h10) begin failures++; $display("FAIL fill_ifaddr got=%h exp=10", IF_ADDR); end
    checks++; if (ID_PC !== 32'h0 || ID_Inst !== 32'h100) begin failures++; $display("FAIL fill_head got=%h/%h exp=0/100", ID_PC, ID_Inst); end
    tick();
    checks++; if (Count !== 3'd4 || IF_ADDR !== 32'h10) begin failures++; $display("FAIL full_hold got=%0d/%h exp=4/10", Count, IF_ADDR); end
  endtask

  task automatic test_full_pop();
    ID_Ready = 1'b1;
    tick();
    checks++; if (Count !== 3'd3) begin failures++; $display("FAIL fullpop_count got=%0d exp=3", Count); end
    checks++; if (ID_PC !== 32'h4 || ID_Inst !== 32'h104) begin failures++; $display("FAIL fullpop_head got=%h/%h exp=4/104", ID_PC, ID_Inst); end
    checks++; if (IF_ADDR !== 32'h10) begin failures++; $display("FAIL fullpop_pc got=%h exp=10", IF_ADDR); end
    ID_Ready = 1'b0;
    tick();
    checks++; if (Count !== 3'd4 || IF_ADDR !== 32'h14) begin failures++; $display("FAIL refill got=%0d/%h exp=4/14", Count, IF_ADDR); end
  endtask

  task automatic test_back_to_back();
    ID_Ready = 1'b1;
    tick();
    checks++; if (Count !== 3'd3 || ID_PC !== 32'h8) begin failures++; $display("FAIL b2b_first got=%0d/%h exp=3/8", Count, ID_PC); end
    tick();
    checks++; if (Count !== 3'd3 || ID_PC !== 32'hC || IF_ADDR !== 32'h18) begin failures++; $display("FAIL b2b_pushpop got=%0d/%h/%h exp=3/c/18", Count, ID_PC, IF_ADDR); end
    ID_Ready = 1'b0;
  endtask

  task automatic test_enable();
    En = 1'b0; ID_Ready = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h80;
    tick(); tick(); tick();
    checks++; if (Count !== 3'd3 || IF_ADDR !== 32'h18) begin failures++; $display("FAIL en_hold_q got=%0d/%h exp=3/18", Count, IF_ADDR); end
    checks++; if (ID_PC !== 32'hC || ID_Inst !== 32'h10C || ID_Valid !== 1'b1) begin failures++; $display("FAIL en_hold_id got=%h/%h exp=c/10c", ID_PC, ID_Inst); end
    checks++; if (Redirect_Cnt !== 16'h0) begin failures++; $display("FAIL en_hold_rcnt got=%h exp=0", Redirect_Cnt); end
    Redirect = 1'b0; ID_Ready = 1'b0; En = 1'b1;
  endtask

  task automatic test_async_reset();
    Rst = 1'b1;
    #2;
    checks++; if (Count !== 3'd0 || ID_Valid !== 1'b0) begin failures++; $display("FAIL arst_q got=%0d/%b exp=0/0", Count, ID_Valid); end
    checks++; if (ID_Inst !== 32'h0 || ID_PC !== 32'h0 || IF_ADDR !== 32'h0) begin failures++; $display("FAIL arst_out got=%h/%h/%h exp=0/0/0", ID_Inst, ID_PC, IF_ADDR); end
    Rst = 1'b0;
    tick(); tick();
    checks++; if (Count !== 3'd2 || ID_PC !== 32'h0 || IF_ADDR !== 32'h8) begin failures++; $display("FAIL arst_restart got=%0d/%h/%h exp=2/0/8", Count, ID_PC, IF_ADDR); end
  endtask

  task automatic test_redirect();
    Redirect = 1'b1; Redirect_PC = 32'h43; ID_Ready = 1'b1;
    tick();
    checks++; if (Count !== 3'd0 || ID_Valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0d/%b exp=0/0", Count, ID_Valid); end
    checks++; if (IF_ADDR !== 32'h40) begin failures++; $display("FAIL redir_pc got=%h exp=40", IF_ADDR); end
    checks++; if (Redirect_Cnt !== 16'h1) begin failures++; $display("FAIL redir_cnt got=%h exp=1", Redirect_Cnt); end
    Redirect = 1'b0;
    tick();
    checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h40 || ID_Inst !== 32'h140) begin failures++; $display("FAIL redir_first got=%b/%h/%h exp=1/40/140", ID_Valid, ID_PC, ID_Inst); end
    checks++; if (Count !== 3'd1 || IF_ADDR !== 32'h44) begin failures++; $display("FAIL ready_empty got=%0d/%h exp=1/44", Count, IF_ADDR); end
    ID_Ready = 1'b0;
    En = 1'b0;
  endtask

  task automatic test_wrap();
    Rst2 = 1'b0; En2 = 1'b1; ID_Ready2 = 1'b0;
    checks++; if (IF_ADDR2 !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_reset_pc got=%h exp=fffffff8", IF_ADDR2); end
    tick();
    checks++; if (ID_PC2 !== 32'hFFFF_FFF8 || ID_Inst2 !== 32'h0000_00F8) begin failures++; $display("FAIL wrap_e0 got=%h/%h exp=fffffff8/f8", ID_PC2, ID_Inst2); end
    tick();
    checks++; if (IF_ADDR2 !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", IF_ADDR2); end
    tick();
    checks++; if (Count2 !== 3'd3 || IF_ADDR2 !== 32'h4) begin failures++; $display("FAIL wrap_count got=%0d/%h exp=3/4", Count2, IF_ADDR2); end
    ID_Ready2 = 1'b1;
    tick();
    checks++; if (ID_PC2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_e1 got=%h exp=fffffffc", ID_PC2); end
    tick();
    checks++; if (ID_PC2 !== 32'h0 || ID_Inst2 !== 32'h100 || Count2 !== 3'd3) begin failures++; $display("FAIL wrap_e2 got=%h/%h/%0d exp=0/100/3", ID_PC2, ID_Inst2, Count2); end
    ID_Ready2 = 1'b0; En2 = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; En = 1'b0; Redirect = 1'b0; Redirect_PC = 32'h0; ID_Ready = 1'b0;
    Rst2 = 1'b1; En2 = 1'b0; ID_Ready2 = 1'b0;
    test_reset();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_redirect();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
